mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM stage of the 5-stage RISC-V pipeline; consumes EX/MEM register outputs, owns the MEM/WB register.
//  Drives the data-memory req/ack bus: byte enables, store-lane replication, load extraction and sign extension.
//  Stalls the pipeline while an access is outstanding.
// PARAMETERS
//  none (XLEN fixed at 32)
// PORTS
//  clk                    in   1   pipeline clock, rising edge
//  rst_n                  in   1   asynchronous active-low reset
//  advance_pc_i           in   32  PC+4 from EX/MEM
//  alu_result_i           in   32  effective address / ALU result
//  reg_2_data_i           in   32  store data (rs2)
//  reg_write_i            in   1   writeback enable
//  reg_write_data_addr_i  in   5   rd
//  mem_width_i            in   2   00 byte, 01 half, 10/11 word
//  mem_sign_extend_i      in   1   1 = sign-extend load
//  reg_src_i              in   2   WB source; 2'b01 = memory (load)
//  mem_write_i            in   1   store
//  dmem_addr_o            out  32  word address {alu_result_i[31:2],2'b00}
//  dmem_req_o             out  1   request, held until ack
//  dmem_we_o              out  1   1 = write
//  dmem_be_o              out  4   byte enables
//  dmem_wdata_o           out  32  lane-replicated store data
//  dmem_rdata_i           in   32  read data, valid with ack
//  dmem_ack_i             in   1   access complete this cycle
//  stall_o                out  1   freeze PC/IF/ID/EX/MEM this cycle
//  reg_write_o            out  1   MEM/WB: writeback enable
//  reg_write_data_addr_o  out  5   MEM/WB: rd
//  reg_src_o              out  2   MEM/WB: WB source
//  alu_result_o           out  32  MEM/WB: ALU result
//  mem_data_o             out  32  MEM/WB: extended load data
//  advance_pc_o           out  32  MEM/WB: PC+4
//  misalign_o             out  1   misaligned-access pulse (MISALIGN_TRAP_EN only)
//  misalign_addr_o        out  32  offending address (MISALIGN_TRAP_EN only)
// BEHAVIOUR
//  - access = mem_write_i | (reg_src_i==2'b01). Upstream holds inputs stable while stall_o=1.
//  - FSM IDLE/WAIT. IDLE: access -> dmem_req_o=1 combinationally; ack same cycle -> zero-wait, stall_o=0, stay IDLE;
//    else stall_o=1, go WAIT. WAIT: dmem_req_o=1, stall_o=!dmem_ack_i; ack -> IDLE. Ack without request ignored.
//  - dmem_we_o=mem_write_i. be: byte 4'b0001<<a[1:0]; half 4'b0011<<{a[1],1'b0}; word 4'b1111.
//  - wdata: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  - load: select lane by a[1:0] (byte) / a[1] (half); zero- or sign-extend per mem_sign_extend_i.
//  - MEM/WB regs load when stall_o=0; while stall_o=1 insert bubble: reg_write_o<=0, others hold.
//  - mem_data_o <= extended dmem_rdata_i on completing load; 0 for non-loads.
//  - Reset: FSM IDLE, all outputs 0 (req drops immediately, even mid-WAIT); post-reset late ack ignored.
//  - Latency: MEM/WB valid 1 edge after ack; zero-wait load = 1 cycle, no stall.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: half with a[0]=1 or word with a[1:0]!=0 -> no dmem_req_o, no stall,
//    bubble (reg_write_o<=0), misalign_o pulses 1 cycle, misalign_addr_o<=a (holds until next).
//  Undefined: misalign ports tied 0; low bits ignored per lane rules (half uses a[1], word aligned).
// TESTING
//  lb a=0x1003, rdata=0x80xxxxxx, ack same cycle, sign=1 -> be=0001<<3=1000, no stall, mem_data_o=0xFFFFFF80.
//  lhu a=0x2002, ack after 3 cycles -> stall_o=1 for 3 cycles, reg_write_o=0 then 1, mem_data_o=rdata[31:16] zero-ext.
//  sb a=0x11, d=0xAB -> we=1, be=0010, wdata=0xABABABAB, reg_write_o=0 (store).
//  rst_n low during WAIT -> req/stall 0 immediately, outputs 0; later ack ignored, next access starts clean.
//  lw a=0x6 with MISALIGN_TRAP_EN -> no req, misalign_o=1 one cycle, misalign_addr_o=0x6, reg_write_o=0.
//  ALU op (reg_src=00, rd=5) -> no req, 1-cycle pass to alu_result_o, reg_write_o=1.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage RV32 pipeline.
// Drives the data-memory req/ack bus (byte enables, lane-replicated store
// data), extracts and extends load data, stalls the pipeline while an access
// is outstanding, and owns the MEM/WB pipeline register.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned half/word accesses are
// suppressed and reported on misalign_o / misalign_addr_o).
module mem_access_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] advance_pc_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] reg_2_data_i,
  input  logic        reg_write_i,
  input  logic [4:0]  reg_write_data_addr_i,
  input  logic [1:0]  mem_width_i,
  input  logic        mem_sign_extend_i,
  input  logic [1:0]  reg_src_i,
  input  logic        mem_write_i,
  output logic [31:0] dmem_addr_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        stall_o,
  output logic        reg_write_o,
  output logic [4:0]  reg_write_data_addr_o,
  output logic [1:0]  reg_src_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] mem_data_o,
  output logic [31:0] advance_pc_o,
  output logic        misalign_o,
  output logic [31:0] misalign_addr_o
);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t state, state_next;
  logic   access;
  logic   is_load;
  logic   trap;
  logic   req;
  logic   stall;

  // Byte enables for the addressed lane(s); word accesses are treated as aligned.
  function automatic logic [3:0] byte_enables(input logic [1:0] width, input logic [1:0] a);
    logic [3:0] be;
    case (width)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = 4'b0011 << {a[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate store data across all lanes so the enabled lane sees it.
  function automatic logic [31:0] store_lanes(input logic [1:0] width, input logic [31:0] d);
    logic [31:0] w;
    case (width)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Pick the addressed lane out of the read word and zero/sign-extend it.
  function automatic logic [31:0] load_extract(input logic [1:0] width, input logic sx,
                                               input logic [1:0] a, input logic [31:0] r);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    case (a)
      2'b00:   b = r[7:0];
      2'b01:   b = r[15:8];
      2'b10:   b = r[23:16];
      default: b = r[31:24];
    endcase
    h = a[1] ? r[31:16] : r[15:0];
    case (width)
      2'b00:   v = sx ? {{24{b[7]}}, b} : {24'b0, b};
      2'b01:   v = sx ? {{16{h[15]}}, h} : {16'b0, h};
      default: v = r;
    endcase
    return v;
  endfunction

  assign access  = mem_write_i | (reg_src_i == 2'b01);
  assign is_load = (reg_src_i == 2'b01);

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((mem_width_i == 2'b01) & alu_result_i[0]) |
                      (mem_width_i[1] & (|alu_result_i[1:0]));
  // A trap can only be raised when a new access is being launched.
  assign trap = access & misaligned & (state == IDLE);
`else
  assign trap = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state, request and stall; reset forces req/stall low immediately.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (access && !trap) begin
          req = 1'b1;
          if (!dmem_ack_i) begin
            stall      = 1'b1;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        req   = 1'b1;
        stall = !dmem_ack_i;
        if (dmem_ack_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!rst_n) begin
      req   = 1'b0;
      stall = 1'b0;
    end
  end

  assign dmem_req_o   = req;
  assign stall_o      = stall;
  assign dmem_addr_o  = rst_n ? {alu_result_i[31:2], 2'b00} : 32'h0;
  assign dmem_we_o    = rst_n & mem_write_i;
  assign dmem_be_o    = rst_n ? byte_enables(mem_width_i, alu_result_i[1:0]) : 4'h0;
  assign dmem_wdata_o = rst_n ? store_lanes(mem_width_i, reg_2_data_i) : 32'h0;

  // MEM/WB register: load when not stalled, otherwise insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_o           <= 1'b0;
      reg_write_data_addr_o <= 5'd0;
      reg_src_o             <= 2'b00;
      alu_result_o          <= 32'h0;
      mem_data_o            <= 32'h0;
      advance_pc_o          <= 32'h0;
    end else if (stall) begin
      reg_write_o <= 1'b0;
    end else begin
      reg_write_o           <= reg_write_i & !trap;
      reg_write_data_addr_o <= reg_write_data_addr_i;
      reg_src_o             <= reg_src_i;
      alu_result_o          <= alu_result_i;
      advance_pc_o          <= advance_pc_i;
      mem_data_o            <= (is_load && !trap)
                               ? load_extract(mem_width_i, mem_sign_extend_i,
                                              alu_result_i[1:0], dmem_rdata_i)
                               : 32'h0;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Misalignment report: one-cycle pulse, address held until the next trap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_o      <= 1'b0;
      misalign_addr_o <= 32'h0;
    end else begin
      misalign_o <= trap;
      if (trap) misalign_addr_o <= alu_result_i;
    end
  end
`else
  assign misalign_o      = 1'b0;
  assign misalign_addr_o = 32'h0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed vectors, an in-bench reference
// model checked on every falling edge, plus hand-computed literal checks.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] advance_pc_i;
  logic [31:0] alu_result_i;
  logic [31:0] reg_2_data_i;
  logic        reg_write_i;
  logic [4:0]  reg_write_data_addr_i;
  logic [1:0]  mem_width_i;
  logic        mem_sign_extend_i;
  logic [1:0]  reg_src_i;
  logic        mem_write_i;
  logic [31:0] dmem_addr_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;
  logic        stall_o;
  logic        reg_write_o;
  logic [4:0]  reg_write_data_addr_o;
  logic [1:0]  reg_src_o;
  logic [31:0] alu_result_o;
  logic [31:0] mem_data_o;
  logic [31:0] advance_pc_o;
  logic        misalign_o;
  logic [31:0] misalign_addr_o;

  int vectors;
  int miscompares;

  mem_access_stage dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .advance_pc_i          (advance_pc_i),
    .alu_result_i          (alu_result_i),
    .reg_2_data_i          (reg_2_data_i),
    .reg_write_i           (reg_write_i),
    .reg_write_data_addr_i (reg_write_data_addr_i),
    .mem_width_i           (mem_width_i),
    .mem_sign_extend_i     (mem_sign_extend_i),
    .reg_src_i             (reg_src_i),
    .mem_write_i           (mem_write_i),
    .dmem_addr_o           (dmem_addr_o),
    .dmem_req_o            (dmem_req_o),
    .dmem_we_o             (dmem_we_o),
    .dmem_be_o             (dmem_be_o),
    .dmem_wdata_o          (dmem_wdata_o),
    .dmem_rdata_i          (dmem_rdata_i),
    .dmem_ack_i            (dmem_ack_i),
    .stall_o               (stall_o),
    .reg_write_o           (reg_write_o),
    .reg_write_data_addr_o (reg_write_data_addr_o),
    .reg_src_o             (reg_src_o),
    .alu_result_o          (alu_result_o),
    .mem_data_o            (mem_data_o),
    .advance_pc_o          (advance_pc_o),
    .misalign_o            (misalign_o),
    .misalign_addr_o       (misalign_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_busy;
  logic        e_rw;
  logic [4:0]  e_rd;
  logic [1:0]  e_src;
  logic [31:0] e_alu, e_mem, e_pc, e_mis_addr;
  logic        e_mis;
  logic        m_acc, m_trap, m_req, m_stall;

  function automatic logic [31:0] model_load(input logic [1:0] w, input logic sx,
                                             input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v;
    if (w == 2'b00) begin
      v = (r >> {a[1:0], 3'b000}) & 32'h0000_00FF;
      if (sx && v[7]) v = v | 32'hFFFF_FF00;
    end else if (w == 2'b01) begin
      v = (r >> {a[1], 4'b0000}) & 32'h0000_FFFF;
      if (sx && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] w, input logic [1:0] a);
    logic [3:0] be;
    if (w == 2'b00) begin
      case (a)
        2'd0:    be = 4'h1;
        2'd1:    be = 4'h2;
        2'd2:    be = 4'h4;
        default: be = 4'h8;
      endcase
    end else if (w == 2'b01) begin
      be = a[1] ? 4'hC : 4'h3;
    end else begin
      be = 4'hF;
    end
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] w, input logic [31:0] d);
    logic [31:0] v;
    if (w == 2'b00)      v = {24'b0, d[7:0]} * 32'h0101_0101;
    else if (w == 2'b01) v = {16'b0, d[15:0]} * 32'h0001_0001;
    else                 v = d;
    return v;
  endfunction

  // Compare DUT against the model every falling edge, then advance the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_req", {31'b0, dmem_req_o}, 32'h0);
      check("rst_stall", {31'b0, stall_o}, 32'h0);
      check("rst_rw", {31'b0, reg_write_o}, 32'h0);
      check("rst_alu", alu_result_o, 32'h0);
      check("rst_mem", mem_data_o, 32'h0);
      check("rst_mis", {31'b0, misalign_o}, 32'h0);
      m_busy = 1'b0; e_rw = 1'b0; e_rd = '0; e_src = '0;
      e_alu = '0; e_mem = '0; e_pc = '0; e_mis = 1'b0; e_mis_addr = '0;
    end else begin
      m_acc = mem_write_i || (reg_src_i == 2'b01);
      m_trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
      if (m_acc && !m_busy &&
          ((mem_width_i == 2'b01 && alu_result_i[0]) ||
           (mem_width_i >= 2'b10 && alu_result_i[1:0] != 2'b00)))
        m_trap = 1'b1;
`endif
      m_req   = m_busy || (m_acc && !m_trap);
      m_stall = m_req && !dmem_ack_i;
      check("req", {31'b0, dmem_req_o}, {31'b0, m_req});
      check("stall", {31'b0, stall_o}, {31'b0, m_stall});
      if (m_req) begin
        check("addr", dmem_addr_o, alu_result_i & 32'hFFFF_FFFC);
        check("we", {31'b0, dmem_we_o}, {31'b0, mem_write_i});
        check("be", {28'b0, dmem_be_o}, {28'b0, model_be(mem_width_i, alu_result_i[1:0])});
        if (mem_write_i)
          check("wdata", dmem_wdata_o, model_wdata(mem_width_i, reg_2_data_i));
      end
      check("rw", {31'b0, reg_write_o}, {31'b0, e_rw});
      check("rd", {27'b0, reg_write_data_addr_o}, {27'b0, e_rd});
      check("src", {30'b0, reg_src_o}, {30'b0, e_src});
      check("alu", alu_result_o, e_alu);
      check("mem", mem_data_o, e_mem);
      check("pc", advance_pc_o, e_pc);
      check("mis", {31'b0, misalign_o}, {31'b0, e_mis});
      check("mis_addr", misalign_addr_o, e_mis_addr);
      if (m_stall) begin
        e_rw = 1'b0;
      end else begin
        e_rw  = reg_write_i && !m_trap;
        e_rd  = reg_write_data_addr_i;
        e_src = reg_src_i;
        e_alu = alu_result_i;
        e_pc  = advance_pc_i;
        e_mem = (reg_src_i == 2'b01 && !m_trap)
                ? model_load(mem_width_i, mem_sign_extend_i, alu_result_i, dmem_rdata_i)
                : 32'h0;
      end
      e_mis = m_trap;
      if (m_trap) e_mis_addr = alu_result_i;
      m_busy = m_stall;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic mw, input logic [1:0] src, input logic rw, input logic [4:0] rd,
                    input logic [1:0] w, input logic sx, input logic [31:0] a, input logic [31:0] d);
    mem_write_i           = mw;
    reg_src_i             = src;
    reg_write_i           = rw;
    reg_write_data_addr_i = rd;
    mem_width_i           = w;
    mem_sign_extend_i     = sx;
    alu_result_i          = a;
    reg_2_data_i          = d;
    advance_pc_i          = advance_pc_i + 32'd4;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    advance_pc_i = 32'h100;
    op(0, 2'b00, 0, 5'd0, 2'b00, 0, 32'h0, 32'h0);
    dmem_rdata_i = 32'h0; dmem_ack_i = 1'b0;
    step(); step();
    check("lit_reset_rw", {31'b0, reg_write_o}, 32'h0);
    check("lit_reset_pc", advance_pc_o, 32'h0);

    // lb a=0x1003, zero-wait, sign-extended 0x80
    rst_n = 1'b1;
    op(0, 2'b01, 1, 5'd3, 2'b00, 1, 32'h1003, 32'h0);
    dmem_rdata_i = 32'h8012_3456; dmem_ack_i = 1'b1;
    @(negedge clk);
    check("lit_lb_be", {28'b0, dmem_be_o}, 32'h8);
    check("lit_lb_stall", {31'b0, stall_o}, 32'h0);
    step();
    check("lit_lb_data", mem_data_o, 32'hFFFF_FF80);
    check("lit_lb_rw", {31'b0, reg_write_o}, 32'h1);

    // lhu a=0x2002, ack after 3 stall cycles
    op(0, 2'b01, 1, 5'd7, 2'b01, 0, 32'h2002, 32'h0);
    dmem_rdata_i = 32'h0; dmem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lit_lhu_stall", {31'b0, stall_o}, 32'h1);
      step();
      check("lit_lhu_bubble", {31'b0, reg_write_o}, 32'h0);
    end
    dmem_rdata_i = 32'hBEEF_1234; dmem_ack_i = 1'b1;
    @(negedge clk);
    check("lit_lhu_release", {31'b0, stall_o}, 32'h0);
    step();
    check("lit_lhu_data", mem_data_o, 32'h0000_BEEF);
    check("lit_lhu_rw", {31'b0, reg_write_o}, 32'h1);

    // sb a=0x11 d=0xAB
    op(1, 2'b00, 0, 5'd0, 2'b00, 0, 32'h11, 32'h0000_00AB);
    dmem_rdata_i = 32'h0;
    @(negedge clk);
    check("lit_sb_we", {31'b0, dmem_we_o}, 32'h1);
    check("lit_sb_be", {28'b0, dmem_be_o}, 32'h2);
    check("lit_sb_wdata", dmem_wdata_o, 32'hABAB_ABAB);
    step();
    check("lit_sb_rw", {31'b0, reg_write_o}, 32'h0);

    // sh a=0x22, upper half lanes
    op(1, 2'b00, 0, 5'd0, 2'b01, 0, 32'h22, 32'h5678_CDEF);
    @(negedge clk);
    check("lit_sh_be", {28'b0, dmem_be_o}, 32'hC);
    check("lit_sh_wdata", dmem_wdata_o, 32'hCDEF_CDEF);
    step();

    // lh a=0x3000 signed, one wait cycle
    op(0, 2'b01, 1, 5'd8, 2'b01, 1, 32'h3000, 32'h0);
    dmem_ack_i = 1'b0;
    step();
    dmem_rdata_i = 32'h1234_8001; dmem_ack_i = 1'b1;
    step();
    check("lit_lh_data", mem_data_o, 32'hFFFF_8001);

    // lbu a=0x4001 zero-extended
    op(0, 2'b01, 1, 5'd9, 2'b00, 0, 32'h4001, 32'h0);
    dmem_rdata_i = 32'h00C3_9A00;
    step();
    check("lit_lbu_data", mem_data_o, 32'h0000_009A);

    // ALU op, rd=5, with a stray ack that must be ignored
    op(0, 2'b00, 1, 5'd5, 2'b10, 0, 32'h1234, 32'h0);
    dmem_ack_i = 1'b1;
    @(negedge clk);
    check("lit_alu_req", {31'b0, dmem_req_o}, 32'h0);
    step();
    check("lit_alu_res", alu_result_o, 32'h1234);
    check("lit_alu_rd", {27'b0, reg_write_data_addr_o}, 32'h5);
    check("lit_alu_rw", {31'b0, reg_write_o}, 32'h1);
    check("lit_alu_mem", mem_data_o, 32'h0);

    // reset while waiting
    op(0, 2'b01, 1, 5'd10, 2'b10, 0, 32'h40, 32'h0);
    dmem_ack_i = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check("lit_rstw_req", {31'b0, dmem_req_o}, 32'h0);
    check("lit_rstw_stall", {31'b0, stall_o}, 32'h0);
    check("lit_rstw_alu", alu_result_o, 32'h0);
    step();
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    step();
    rst_n = 1'b1;
    op(0, 2'b00, 0, 5'd0, 2'b00, 0, 32'h0, 32'h0);
    step();
    check("lit_late_ack_rw", {31'b0, reg_write_o}, 32'h0);
    check("lit_late_ack_mem", mem_data_o, 32'h0);
    op(0, 2'b01, 1, 5'd11, 2'b10, 0, 32'h44, 32'h0);
    dmem_rdata_i = 32'hCAFE_F00D; dmem_ack_i = 1'b1;
    step();
    check("lit_clean_lw", mem_data_o, 32'hCAFE_F00D);
    check("lit_clean_rw", {31'b0, reg_write_o}, 32'h1);

    // lw a=0x6
    op(0, 2'b01, 1, 5'd4, 2'b10, 0, 32'h6, 32'h0);
    dmem_ack_i = 1'b0; dmem_rdata_i = 32'h1111_2222;
`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    check("lit_mis_req", {31'b0, dmem_req_o}, 32'h0);
    check("lit_mis_stall", {31'b0, stall_o}, 32'h0);
    step();
    check("lit_mis_pulse", {31'b0, misalign_o}, 32'h1);
    check("lit_mis_addr", misalign_addr_o, 32'h6);
    check("lit_mis_rw", {31'b0, reg_write_o}, 32'h0);
    op(0, 2'b00, 0, 5'd0, 2'b00, 0, 32'h0, 32'h0);
    step();
    check("lit_mis_end", {31'b0, misalign_o}, 32'h0);
    check("lit_mis_hold", misalign_addr_o, 32'h6);
`else
    dmem_ack_i = 1'b1;
    @(negedge clk);
    check("lit_lw6_addr", dmem_addr_o, 32'h4);
    step();
    check("lit_lw6_data", mem_data_o, 32'h1111_2222);
    check("lit_lw6_mis", {31'b0, misalign_o}, 32'h0);
    op(0, 2'b00, 0, 5'd0, 2'b00, 0, 32'h0, 32'h0);
`endif
    dmem_ack_i = 1'b0;
    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
